// File: rtl/spram_port_ctrl.sv
// Port A controller for the single-port RAM wrapper: valid/ready requests in,
// registered RAM address/data/write-enable out, read latency absorbed, plus a clear engine.
module spram_port_ctrl #(
    parameter int                   DATAWIDTH  = 32,
    parameter int                   ADDRWIDTH  = 10,
    parameter int                   RD_LATENCY = 2,
    parameter logic [DATAWIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 req_vld,
    output logic                 req_rdy,
    input  logic                 req_wr,
    input  logic [ADDRWIDTH-1:0] req_addr,
    input  logic [DATAWIDTH-1:0] req_wdata,
    output logic                 rsp_vld,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_din,
    output logic                 ram_we,
    input  logic [DATAWIDTH-1:0] ram_dout
);

    localparam int               LW    = $clog2(RD_LATENCY + 1);
    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP, CLEAR} state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        lat_cnt;
    logic [ADDRWIDTH:0]   clr_cnt;
    logic                 accept;
    logic                 lat_done;
    logic                 clr_last;

    assign accept   = req_vld & req_rdy;
    assign lat_done = (lat_cnt == '0);
    assign clr_last = (clr_cnt == DEPTH);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clr_start)            state_nxt = CLEAR;
                else if (accept && !req_wr) state_nxt = RD_WAIT;
            end
            RD_WAIT: if (lat_done) state_nxt = RSP;
            RSP:     state_nxt = (accept && !req_wr) ? RD_WAIT : IDLE;
            CLEAR:   if (clr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RSP also accepts a request so reads can be issued back to back with the response.
    always_comb begin
        req_rdy  = 1'b0;
        rsp_vld  = 1'b0;
        clr_busy = 1'b0;
        case (state)
            IDLE:  req_rdy = rst_b & ~clr_start;
            RSP: begin
                rsp_vld = 1'b1;
                req_rdy = rst_b;
            end
            CLEAR: clr_busy = 1'b1;
            default: ;
        endcase
    end

    // lat_cnt counts down from RD_LATENCY starting in the address cycle, so RD_WAIT
    // lasts RD_LATENCY+1 cycles; clr_cnt holds the next clear address to issue.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            rsp_rdata <= '0;
            clr_done  <= 1'b0;
            lat_cnt   <= '0;
            clr_cnt   <= '0;
        end else begin
            ram_we   <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE, RSP: begin
                    if (state == IDLE && clr_start) begin
                        ram_addr <= '0;
                        ram_din  <= FILL_VALUE;
                        ram_we   <= 1'b1;
                        clr_cnt  <= (ADDRWIDTH+1)'(1);
                    end else if (accept) begin
                        ram_addr <= req_addr;
                        if (req_wr) begin
                            ram_din <= req_wdata;
                            ram_we  <= 1'b1;
                        end else begin
                            lat_cnt <= LW'(RD_LATENCY);
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_done) rsp_rdata <= ram_dout;
                    else          lat_cnt   <= lat_cnt - LW'(1);
                end
                CLEAR: begin
                    if (clr_last) begin
                        clr_done <= 1'b1;
                        clr_cnt  <= '0;
                    end else begin
                        ram_addr <= clr_cnt[ADDRWIDTH-1:0];
                        ram_din  <= FILL_VALUE;
                        ram_we   <= 1'b1;
                        clr_cnt  <= clr_cnt + (ADDRWIDTH+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
